// File: rtl/keypad_key_fifo_pkg.sv
// ----------------------------------------------------------------------------
// keypad_key_fifo_pkg
//   Definitions shared by the keypad key FIFO and the keypad controller side:
//   key code width, default FIFO depth and the capture-state encodings.
// ----------------------------------------------------------------------------
package keypad_key_fifo_pkg;

  localparam int KEY_W        = 4;  // keypad_data width of keypad_controller
  localparam int FIFO_DEPTH   = 8;  // default number of FIFO entries
  localparam int FIFO_ADDR_W  = 3;  // log2(FIFO_DEPTH)

  // Capture FSM: waits for the key interrupt, then waits for its release.
  typedef enum logic {
    WAIT_PRESS = 1'b0,
    HELD       = 1'b1
  } cap_state_e;

endpackage : keypad_key_fifo_pkg

// File: rtl/keypad_key_fifo_capture.sv
// ----------------------------------------------------------------------------
// keypad_key_fifo_capture
//   Key event capture for the keypad key FIFO. Turns the controller interrupt
//   (level or pulse) into exactly one push strobe per key event: a push is
//   issued in the cycle the interrupt is first seen high, and no further push
//   happens until the interrupt has been low for at least one cycle.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   i_interrupt   in   key event from keypad_controller
//   i_keypad_data in   key code, forwarded with the push strobe
//   o_push        out  1-cycle push strobe (combinational, same cycle as edge)
//   o_code        out  key code to store when o_push is high
// ----------------------------------------------------------------------------
module keypad_key_fifo_capture
  import keypad_key_fifo_pkg::*;
#(
  parameter int DATA_W = KEY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_interrupt,
  input  logic [DATA_W-1:0] i_keypad_data,
  output logic              o_push,
  output logic [DATA_W-1:0] o_code
);

  cap_state_e r_state;
  cap_state_e w_next_state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT_PRESS;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    o_push       = 1'b0;
    case (r_state)
      WAIT_PRESS: begin
        if (i_interrupt) begin
          o_push       = 1'b1;
          w_next_state = HELD;
        end
      end
      HELD: begin
        if (!i_interrupt) w_next_state = WAIT_PRESS;
      end
      default: w_next_state = WAIT_PRESS;
    endcase
  end

  assign o_code = i_keypad_data;

endmodule : keypad_key_fifo_capture

// File: rtl/keypad_key_fifo.sv
// ----------------------------------------------------------------------------
// keypad_key_fifo
//   Buffers key codes from keypad_controller in a small FIFO and hands them to
//   the host through a registered read port.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high; clears all state
//   interrupt     in   key event from keypad_controller
//   keypad_data   in   key code, sampled in the cycle the event is seen
//   rd_en         in   pop request
//   clr_overflow  in   clears the sticky overflow flag
//   flush         in   synchronous empty of the FIFO
//   rd_data       out  popped key code, registered, holds when rd_valid=0
//   rd_valid      out  1-cycle pulse when rd_data was updated
//   empty/full    out  count == 0 / count == DEPTH
//   count         out  entries held, 0..DEPTH
//   overflow      out  sticky: a key event was dropped while full
//   irq           out  level, ~empty
// ----------------------------------------------------------------------------
module keypad_key_fifo
  import keypad_key_fifo_pkg::*;
#(
  parameter int DATA_W = KEY_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              interrupt,
  input  logic [DATA_W-1:0] keypad_data,
  input  logic              rd_en,
  input  logic              clr_overflow,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              irq
);

  localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;

  logic              w_push;
  logic [DATA_W-1:0] w_code;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;

  keypad_key_fifo_capture #(
    .DATA_W(DATA_W)
  ) u_capture (
    .clk          (clk),
    .reset        (reset),
    .i_interrupt  (interrupt),
    .i_keypad_data(keypad_data),
    .o_push       (w_push),
    .o_code       (w_code)
  );

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  // A pop on an empty FIFO is ignored even if a push lands in the same cycle.
  assign w_pop     = rd_en && !w_empty;
  // When full, a same-cycle pop frees the slot, so the push is accepted.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= w_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (flush) begin
      // Flush overrides any same-cycle push and pop.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_overflow <= 1'b0;
    else if (w_drop && !flush) r_overflow <= 1'b1;
    else if (clr_overflow) r_overflow <= 1'b0;
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign irq      = !w_empty;

endmodule : keypad_key_fifo
